ss_display_ctrl: RTL and testbench
==================================

SS_DISPLAY_CTRL -- requirements
Module: ss_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DISPLAYS, default 6, number of digits, legal range 1..8.
REQ-002 SHALL have parameter NUM_SEGMENTS, default 8, segment bits per digit, legal 7 or 8 (8 includes dp).
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000, CLK cycles per blink half-period, at least 2.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nRST, input, 1, reset, asynchronous assert and active-low.
REQ-006 SHALL have port load_valid, input, 1, request to sample a new frame.
REQ-007 SHALL have port load_ready, output, 1, high only in IDLE; a load is accepted when load_valid and load_ready are both high.
REQ-008 SHALL have port number, input, 4*NUM_DISPLAYS, nibble i for digit i.
REQ-009 SHALL have port en_mask, input, NUM_DISPLAYS, digit enable (0 = blank).
REQ-010 SHALL have port dp_mask, input, NUM_DISPLAYS, decimal point on (ignored when NUM_SEGMENTS=7).
REQ-011 SHALL have port blink_mask, input, NUM_DISPLAYS, digits that blink.
REQ-012 SHALL have port lz_blank, input, 1, leading-zero suppression enable.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a frame update completes.
REQ-014 SHALL have port SS, output, NUM_DISPLAYS x NUM_SEGMENTS, registered active-low segments, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-015 SHALL capture number, en_mask, dp_mask, blink_mask and lz_blank into frame registers on the accepting edge; inputs are ignored at all other times.
REQ-016 SHALL implement FSM IDLE -> UPDATE (on accept) -> DONE (after the digit-0 write) -> IDLE (unconditionally).
REQ-017 SHALL, in UPDATE, walk digit index from NUM_DISPLAYS-1 down to 0, writing one digit's shadow segments per cycle, so UPDATE lasts exactly NUM_DISPLAYS cycles.
REQ-018 SHALL assert done for exactly the single DONE cycle, NUM_DISPLAYS+1 cycles after the accepting edge.
REQ-019 SHALL hold load_ready low in UPDATE and DONE; load_valid in those states has no effect and no frame is queued.
REQ-020 SHALL decode each nibble to standard hex glyphs 0-F; dp segment on when dp_mask bit is set.
REQ-021 SHALL blank a digit fully (all segments 1, including dp) when its en_mask bit is 0; a disabled digit counts as zero for leading-zero tracking.
REQ-022 SHALL, when lz_blank is set, blank a digit whose value is zero and whose higher digits are all zero; digit 0 is never suppressed; dp of a suppressed digit still follows dp_mask.
REQ-023 SHALL run a free-running blink counter 0..BLINK_DIV-1 from reset, toggling blink_phase (reset 0) on each wrap.
REQ-024 SHALL drive SS[i] all-ones when blink_phase=1 and the captured blink_mask[i]=1; otherwise SS[i] equals shadow[i].
REQ-025 SHALL register SS from the next-shadow value, so a digit written in an UPDATE cycle appears on SS at that cycle's closing edge, and a blink-phase change appears on SS on the same edge as the toggle.
REQ-026 SHALL leave digits not yet rewritten showing their previous frame value during UPDATE.

Reset
REQ-027 SHALL, on nRST low, asynchronously force: state IDLE, SS all ones, shadow all ones, frame registers 0, blink counter 0, blink_phase 0, done 0.
REQ-028 SHALL abandon any in-progress UPDATE on reset mid-frame; after release the block is in IDLE with load_ready 1 and all digits dark.

Structure
REQ-029 SHALL place the FSM state enum, SEG_OFF constant (all ones) and the 16-entry active-low glyph table in shared package ss_pkg.
REQ-030 SHALL instantiate one combinational sub-module ss_hex_decode (nibble, dp, blank -> segments) for the single digit selected by the walk index.

Verification
REQ-031 SHALL cover: reset -> SS all 8'hFF, load_ready=1, done=0.
REQ-032 SHALL cover: NUM_DISPLAYS=6, load number=24'h000120, en_mask=6'h3F, lz_blank=0 -> done 7 cycles after accept; SS[0]=8'hC0, SS[1]=8'hA4, SS[2]=8'hF9, SS[5..3]=8'hC0.
REQ-033 SHALL cover: same frame with lz_blank=1 -> SS[5..3]=8'hFF, SS[2..0] unchanged; number=0 -> only SS[0]=8'hC0.
REQ-034 SHALL cover: load_valid held high through UPDATE with a different number -> second frame not applied until accepted after done; exactly one done per accept.
REQ-035 SHALL cover: BLINK_DIV=4, blink_mask=6'h01, number nibble0=4'hF -> SS[0] alternates 8'h8E / 8'hFF every 4 cycles, other digits steady.
REQ-036 SHALL cover: nRST pulsed low mid-UPDATE -> SS immediately 8'hFF for all digits, no done, new load accepted normally afterwards.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Glyphs are active-low {g,f,e,d,c,b,a}; the dp bit is added by the decoder.
package ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n is the glyph for hex digit n (entry 15 is the leftmost element).
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/ss_hex_decode.sv
// Combinational nibble-to-segment decoder for one digit, active-low outputs.
// blank turns off the glyph segments only; dp is controlled separately.
module ss_hex_decode
    import ss_pkg::*;
#(
    parameter int NUM_SEGMENTS = 8
) (
    input  logic [3:0]              i_nibble,
    input  logic                    i_dp,
    input  logic                    i_blank,
    output logic [NUM_SEGMENTS-1:0] o_seg
);

    logic [6:0] w_glyph;
    logic [7:0] w_full;

    always_comb begin
        w_glyph = i_blank ? SEG_OFF[6:0] : GLYPH_TABLE[i_nibble];
        w_full  = {~i_dp, w_glyph};
        o_seg   = w_full[NUM_SEGMENTS-1:0];
    end

endmodule

// File: rtl/ss_display_ctrl.sv
// Multi-digit seven-segment controller: captures a frame on a valid/ready load,
// then rewrites one digit per cycle from the top digit down, with blinking.
module ss_display_ctrl
    import ss_pkg::*;
#(
    parameter int NUM_DISPLAYS = 6,
    parameter int NUM_SEGMENTS = 8,
    parameter int BLINK_DIV    = 25_000_000
) (
    input  logic                                      CLK,
    input  logic                                      nRST,
    input  logic                                      load_valid,
    output logic                                      load_ready,
    input  logic [4*NUM_DISPLAYS-1:0]                 number,
    input  logic [NUM_DISPLAYS-1:0]                   en_mask,
    input  logic [NUM_DISPLAYS-1:0]                   dp_mask,
    input  logic [NUM_DISPLAYS-1:0]                   blink_mask,
    input  logic                                      lz_blank,
    output logic                                      done,
    output logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0] SS,
    output state_t                                    o_dbg_state
);

    localparam int IDX_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [NUM_SEGMENTS-1:0] DIGIT_OFF = SEG_OFF[NUM_SEGMENTS-1:0];

    // Handshake: a frame is accepted on a rising edge where load_valid and
    // load_ready are both high; load_ready is high only while in IDLE.
    state_t                                    r_state;
    logic [IDX_W-1:0]                          r_idx;
    logic                                      r_load_ready;
    logic                                      r_done;
    logic                                      r_zero_above;

    logic [4*NUM_DISPLAYS-1:0]                 r_number;
    logic [NUM_DISPLAYS-1:0]                   r_en;
    logic [NUM_DISPLAYS-1:0]                   r_dp;
    logic [NUM_DISPLAYS-1:0]                   r_blink;
    logic                                      r_lz;

    logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0] r_shadow;
    logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0] r_ss;
    logic [CNT_W-1:0]                          r_blink_cnt;
    logic                                      r_phase;

    logic                                      w_accept;
    logic [3:0]                                w_nibble;
    logic                                      w_en;
    logic                                      w_dp;
    logic                                      w_digit_zero;
    logic                                      w_suppress;
    logic [NUM_SEGMENTS-1:0]                   w_seg;
    logic                                      w_wrap;
    logic                                      w_phase_next;
    logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0] w_shadow_next;
    logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0] w_ss_next;

    assign w_accept     = load_valid && r_load_ready;
    assign load_ready   = r_load_ready;
    assign done         = r_done;
    assign SS           = r_ss;
    assign o_dbg_state  = r_state;

    always_comb begin
        w_nibble = 4'h0;
        w_en     = 1'b0;
        w_dp     = 1'b0;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_number[4*i +: 4];
                w_en     = r_en[i];
                w_dp     = r_dp[i];
            end
        end
    end

    // A disabled digit counts as zero when tracking leading zeros.
    assign w_digit_zero = !w_en || (w_nibble == 4'h0);
    assign w_suppress   = r_lz && r_zero_above && w_digit_zero && (r_idx != '0);

    ss_hex_decode #(
        .NUM_SEGMENTS (NUM_SEGMENTS)
    ) u_decode (
        .i_nibble (w_nibble),
        .i_dp     (w_en && w_dp),
        .i_blank  (!w_en || w_suppress),
        .o_seg    (w_seg)
    );

    assign w_wrap       = (r_blink_cnt == CNT_W'(BLINK_DIV - 1));
    assign w_phase_next = r_phase ^ w_wrap;

    always_comb begin
        w_shadow_next = r_shadow;
        w_ss_next     = r_shadow;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            if (r_state == ST_UPDATE && r_idx == IDX_W'(i)) begin
                w_shadow_next[i] = w_seg;
            end
        end
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            w_ss_next[i] = (w_phase_next && r_blink[i]) ? DIGIT_OFF : w_shadow_next[i];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b0;
            r_zero_above <= 1'b0;
            r_number     <= '0;
            r_en         <= '0;
            r_dp         <= '0;
            r_blink      <= '0;
            r_lz         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_number     <= number;
                        r_en         <= en_mask;
                        r_dp         <= (NUM_SEGMENTS == 8) ? dp_mask : '0;
                        r_blink      <= blink_mask;
                        r_lz         <= lz_blank;
                        r_idx        <= IDX_W'(NUM_DISPLAYS - 1);
                        r_zero_above <= 1'b1;
                        r_load_ready <= 1'b0;
                        r_state      <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_zero_above <= r_zero_above && w_digit_zero;
                    if (r_idx == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // SS is loaded from the next-shadow view so writes and blink toggles land on the same edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_shadow    <= '1;
            r_ss        <= '1;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_next;
            r_ss        <= w_ss_next;
            r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + 1'b1;
            r_phase     <= w_phase_next;
        end
    end

endmodule

// File: tb/tb_ss_display_ctrl.sv
// Directed bench for ss_display_ctrl with six digits and a short blink period.
module tb_ss_display_ctrl;
    import ss_pkg::*;

    localparam int N  = 6;
    localparam int NS = 8;
    localparam int BD = 4;

    logic                   CLK;
    logic                   nRST;
    logic                   load_valid;
    logic                   load_ready;
    logic [4*N-1:0]         number;
    logic [N-1:0]           en_mask;
    logic [N-1:0]           dp_mask;
    logic [N-1:0]           blink_mask;
    logic                   lz_blank;
    logic                   done;
    logic [N-1:0][NS-1:0]   SS;
    state_t                 dbg_state;

    int checks;
    int errors;

    ss_display_ctrl #(
        .NUM_DISPLAYS (N),
        .NUM_SEGMENTS (NS),
        .BLINK_DIV    (BD)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .number      (number),
        .en_mask     (en_mask),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .lz_blank    (lz_blank),
        .done        (done),
        .SS          (SS),
        .o_dbg_state (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver: present one frame, let it be accepted, wait (bounded) for done.
    task automatic load_frame(input logic [4*N-1:0] num, input logic [N-1:0] en,
                              input logic [N-1:0] dp, input logic [N-1:0] bl, input logic lz);
        int k;
        @(negedge CLK);
        number = num; en_mask = en; dp_mask = dp; blink_mask = bl; lz_blank = lz;
        load_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        load_valid = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL load_done_timeout: done=%0b required 1 within 20 cycles", done);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0; load_valid = 1'b0; number = '0; en_mask = '0;
        dp_mask = '0; blink_mask = '0; lz_blank = 1'b0;
        #12;
        checks++;
        if (SS !== {N{8'hFF}}) begin
            errors++; $display("FAIL reset_ss: got %h required %h", SS, {N{8'hFF}});
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", load_ready);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b required 0", done);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    // Accept-to-done timing and load_ready behaviour, cycle by cycle.
    task automatic test_latency();
        logic [N-1:0][7:0] exp_ss;
        @(negedge CLK);
        number = 24'h000120; en_mask = 6'h3F; dp_mask = '0; blink_mask = '0; lz_blank = 1'b0;
        load_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        load_valid = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            checks++;
            if (done !== (cyc == 7)) begin
                errors++; $display("FAIL latency_done cycle %0d: got %b required %b", cyc, done, cyc == 7);
            end
            checks++;
            if (load_ready !== (cyc == 8)) begin
                errors++; $display("FAIL latency_ready cycle %0d: got %b required %b", cyc, load_ready, cyc == 8);
            end
            if (cyc < 8) @(negedge CLK);
        end
        exp_ss = {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hC0};
        for (int i = 0; i < N; i++) begin
            checks++;
            if (SS[i] !== exp_ss[i]) begin
                errors++; $display("FAIL basic_ss[%0d]: got %h required %h", i, SS[i], exp_ss[i]);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [N-1:0][7:0] exp_ss;
        load_frame(24'h000120, 6'h3F, 6'h00, 6'h00, 1'b1);
        exp_ss = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hC0};
        for (int i = 0; i < N; i++) begin
            checks++;
            if (SS[i] !== exp_ss[i]) begin
                errors++; $display("FAIL lz_ss[%0d]: got %h required %h", i, SS[i], exp_ss[i]);
            end
        end
        load_frame(24'h000000, 6'h3F, 6'h04, 6'h00, 1'b1);
        exp_ss = {8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'hC0};
        for (int i = 0; i < N; i++) begin
            checks++;
            if (SS[i] !== exp_ss[i]) begin
                errors++; $display("FAIL lz_zero_ss[%0d]: got %h required %h", i, SS[i], exp_ss[i]);
            end
        end
    endtask

    task automatic test_enable_mask();
        logic [N-1:0][7:0] exp_ss;
        load_frame(24'h000120, 6'h3E, 6'h01, 6'h00, 1'b1);
        exp_ss = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hFF};
        for (int i = 0; i < N; i++) begin
            checks++;
            if (SS[i] !== exp_ss[i]) begin
                errors++; $display("FAIL en_ss[%0d]: got %h required %h", i, SS[i], exp_ss[i]);
            end
        end
    endtask

    // Hex letters plus a dp, and the top-down walk leaving lower digits untouched.
    task automatic test_walk_hex();
        logic [N-1:0][7:0] old_ss;
        logic [N-1:0][7:0] exp_ss;
        old_ss = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hFF};
        exp_ss = {8'h08, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        @(negedge CLK);
        number = 24'hABCDEF; en_mask = 6'h3F; dp_mask = 6'h20; blink_mask = '0; lz_blank = 1'b0;
        load_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        load_valid = 1'b0;
        checks++;
        if (SS !== old_ss) begin
            errors++; $display("FAIL walk_first_cycle: got %h required %h", SS, old_ss);
        end
        @(negedge CLK);
        checks++;
        if (SS !== {exp_ss[5], old_ss[4:0]}) begin
            errors++; $display("FAIL walk_top_digit: got %h required %h", SS, {exp_ss[5], old_ss[4:0]});
        end
        @(negedge CLK);
        checks++;
        if (SS !== {exp_ss[5:4], old_ss[3:0]}) begin
            errors++; $display("FAIL walk_second_digit: got %h required %h", SS, {exp_ss[5:4], old_ss[3:0]});
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL walk_done: got %b required 1", done);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (SS[i] !== exp_ss[i]) begin
                errors++; $display("FAIL hex_ss[%0d]: got %h required %h", i, SS[i], exp_ss[i]);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int ndone;
        int nacc;
        @(negedge CLK);
        number = 24'h000001; en_mask = 6'h3F; dp_mask = '0; blink_mask = '0; lz_blank = 1'b0;
        load_valid = 1'b1;
        nacc = 0;
        if (load_ready) nacc++;
        @(posedge CLK);
        @(negedge CLK);
        number = 24'h000002;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (load_valid && load_ready) nacc++;
            if (done) begin
                ndone++;
                checks++;
                if (ndone == 1 && SS[0] !== 8'hF9) begin
                    errors++; $display("FAIL b2b_first_frame: got %h required f9", SS[0]);
                end else if (ndone == 2 && SS[0] !== 8'hA4) begin
                    errors++; $display("FAIL b2b_second_frame: got %h required a4", SS[0]);
                end
                if (ndone == 2) load_valid = 1'b0;
            end
            if (ndone == 1 && !done && load_ready) begin
                checks++;
                if (SS[0] !== 8'hF9) begin
                    errors++; $display("FAIL b2b_hold: got %h required f9", SS[0]);
                end
            end
            @(negedge CLK);
        end
        load_valid = 1'b0;
        checks++;
        if (ndone !== 2) begin
            errors++; $display("FAIL b2b_done_count: got %0d required 2", ndone);
        end
        checks++;
        if (nacc !== 2) begin
            errors++; $display("FAIL b2b_accept_count: got %0d required 2", nacc);
        end
    endtask

    task automatic test_blink();
        logic [7:0] s[0:23];
        logic [7:0] exp;
        logic [7:0] other;
        int t0;
        load_frame(24'h00000F, 6'h3F, 6'h00, 6'h01, 1'b0);
        for (int i = 0; i < 24; i++) begin
            s[i] = SS[0];
            checks++;
            if (SS[1] !== 8'hC0) begin
                errors++; $display("FAIL blink_steady[%0d]: got %h required c0", i, SS[1]);
            end
            @(negedge CLK);
        end
        t0 = 0;
        for (int i = 23; i > 0; i--) if (s[i] !== s[i-1]) t0 = i;
        checks++;
        if (t0 == 0 || t0 > 4 || (s[t0] !== 8'h8E && s[t0] !== 8'hFF)) begin
            errors++; $display("FAIL blink_start: edge at %0d value %h required edge in 1..4 to 8e/ff", t0, s[t0]);
        end else begin
            other = (s[t0] == 8'h8E) ? 8'hFF : 8'h8E;
            for (int i = t0; i < t0 + 16; i++) begin
                exp = (((i - t0) / 4) % 2 == 0) ? s[t0] : other;
                checks++;
                if (s[i] !== exp) begin
                    errors++; $display("FAIL blink_pattern[%0d]: got %h required %h", i, s[i], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_update();
        logic [N-1:0][7:0] exp_ss;
        int ndone;
        @(negedge CLK);
        number = 24'h123456; en_mask = 6'h3F; dp_mask = '0; blink_mask = '0; lz_blank = 1'b0;
        load_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        load_valid = 1'b0;
        repeat (2) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (SS !== {N{8'hFF}}) begin
            errors++; $display("FAIL midreset_ss: got %h required all ff", SS);
        end
        checks++;
        if (done !== 1'b0 || load_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ctrl: done=%b ready=%b required 0/1", done, load_ready);
        end
        @(negedge CLK);
        nRST = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge CLK);
        end
        checks++;
        if (ndone !== 0 || SS !== {N{8'hFF}} || load_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_after: dones=%0d ss=%h ready=%b required 0/all ff/1", ndone, SS, load_ready);
        end
        load_frame(24'h000120, 6'h3F, 6'h00, 6'h00, 1'b0);
        exp_ss = {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hC0};
        checks++;
        if (SS !== exp_ss) begin
            errors++; $display("FAIL midreset_reload: got %h required %h", SS, exp_ss);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_lz_blank();
        test_enable_mask();
        test_walk_hex();
        test_back_to_back();
        test_blink();
        test_reset_mid_update();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
